// File: rtl/wbu_trap_csr_pkg.sv
// Shared CSR addresses, mstatus field positions, trap cause codes and the flush FSM state type
// for the write-back stage.
package wbu_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [4:0] CAUSE_ECALL_M    = 5'd11;
   localparam logic [4:0] CAUSE_BREAKPOINT = 5'd3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } wbu_state_e;

   // Only MIE/MPIE are stored; MPP is hard-wired to M-mode.
   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] v;
      v = '0;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      v[MSTATUS_MIE]  = mie;
      v[MSTATUS_MPIE] = mpie;
      return v;
   endfunction

endpackage

// File: rtl/wbu_trap_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to either half wins over that cycle's increment; the other half is kept.
module csr_counter64 (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc,
   input  logic        wen_lo,
   input  logic        wen_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   logic [63:0] cnt_q;
   logic [63:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (wen_lo) begin
         cnt_d[31:0] = wdata;
      end else if (wen_hi) begin
         cnt_d[63:32] = wdata;
      end else if (inc) begin
         cnt_d = cnt_q + 64'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;

endmodule

// File: rtl/wbu_trap_csr.sv
// Write-back stage with writable M-mode trap CSRs; retires one instruction per cycle and raises a
// registered one-cycle flush. Define WBU_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module wbu_trap_csr
   import wbu_csr_pkg::*;
#(
   parameter int          XLEN          = 32,
   parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
   parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
   parameter logic [31:0] MARCHID_VAL   = 32'h015f_deeb,
   parameter logic [31:0] MHARTID_VAL   = 32'h0
) (
   input  logic            clock,
   input  logic            reset,
   output logic            gpr_wen,
   output logic [4:0]      gpr_waddr,
   output logic [XLEN-1:0] gpr_wdata,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   output logic            cs_flush,
   output logic [XLEN-1:0] cs_dnpc,
   output logic            fencei,
   output logic            in_ready,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_pc,
   input  logic [4:0]      in_gpr_waddr,
   input  logic [XLEN-1:0] in_gpr_wdata,
   input  logic            in_csr_wen,
   input  logic [11:0]     in_csr_waddr,
   input  logic [XLEN-1:0] in_csr_wdata,
   input  logic            in_exc,
   input  logic [4:0]      in_exc_cause,
   input  logic [XLEN-1:0] in_exc_tval,
   input  logic            in_ret,
   input  logic            in_fencei
);

   wbu_state_e      state_q, state_d;
   logic [XLEN-1:0] dnpc_q, dnpc_d;
   logic            fencei_q, fencei_d;
   logic            mie_q, mie_d;
   logic            mpie_q, mpie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;

   logic accept;
   logic take_exc;
   logic take_ret;
   logic csr_we;

   // ebreak arrives as in_exc & in_ret and is taken purely as an exception.
   assign in_ready = (state_q == ST_RUN);
   assign accept   = in_valid & in_ready;
   assign take_exc = accept & in_exc;
   assign take_ret = accept & in_ret & ~in_exc;
   assign csr_we   = accept & in_csr_wen & ~in_exc & ~in_ret;

   assign gpr_wen   = accept & ~in_exc & (in_gpr_waddr != 5'd0);
   assign gpr_waddr = in_gpr_waddr;
   assign gpr_wdata = in_gpr_wdata;

   assign cs_flush = (state_q == ST_FLUSH);
   assign cs_dnpc  = dnpc_q;
   assign fencei   = cs_flush & fencei_q;

`ifdef WBU_COUNTERS_EN
   logic [63:0] mcycle;
   logic [63:0] minstret;

   csr_counter64 u_mcycle (
      .clock  (clock),
      .reset  (reset),
      .inc    (1'b1),
      .wen_lo (csr_we && (in_csr_waddr == CSR_MCYCLE)),
      .wen_hi (csr_we && (in_csr_waddr == CSR_MCYCLEH)),
      .wdata  (in_csr_wdata),
      .value  (mcycle)
   );

   csr_counter64 u_minstret (
      .clock  (clock),
      .reset  (reset),
      .inc    (accept),
      .wen_lo (csr_we && (in_csr_waddr == CSR_MINSTRET)),
      .wen_hi (csr_we && (in_csr_waddr == CSR_MINSTRETH)),
      .wdata  (in_csr_wdata),
      .value  (minstret)
   );
`endif

   // Redirect target is captured from pre-update CSR values on the accepting cycle.
   always_comb begin
      state_d  = state_q;
      dnpc_d   = dnpc_q;
      fencei_d = fencei_q;
      case (state_q)
         ST_RUN: begin
            if (accept & (in_exc | in_ret | in_csr_wen | in_fencei)) begin
               state_d  = ST_FLUSH;
               fencei_d = in_fencei & ~in_exc;
               if (take_exc) begin
                  dnpc_d = mtvec_q;
               end else if (take_ret) begin
                  dnpc_d = mepc_q;
               end else begin
                  dnpc_d = in_pc + XLEN'(4);
               end
            end
         end
         ST_FLUSH: begin
            state_d  = ST_RUN;
            fencei_d = 1'b0;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      mscratch_d = mscratch_q;
      if (take_exc) begin
         mepc_d   = in_pc;
         mcause_d = {{(XLEN-5){1'b0}}, in_exc_cause};
         mtval_d  = in_exc_tval;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (take_ret) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (csr_we) begin
         case (in_csr_waddr)
            CSR_MSTATUS: begin
               mie_d  = in_csr_wdata[MSTATUS_MIE];
               mpie_d = in_csr_wdata[MSTATUS_MPIE];
            end
            CSR_MTVEC:    mtvec_d    = {in_csr_wdata[XLEN-1:2], 2'b00};
            CSR_MEPC:     mepc_d     = {in_csr_wdata[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_d   = in_csr_wdata;
            CSR_MTVAL:    mtval_d    = in_csr_wdata;
            CSR_MSCRATCH: mscratch_d = in_csr_wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         CSR_MSTATUS:   csr_rdata = mstatus_pack(mie_q, mpie_q);
         CSR_MTVEC:     csr_rdata = mtvec_q;
         CSR_MEPC:      csr_rdata = mepc_q;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MTVAL:     csr_rdata = mtval_q;
         CSR_MSCRATCH:  csr_rdata = mscratch_q;
         CSR_MVENDORID: csr_rdata = MVENDORID_VAL;
         CSR_MARCHID:   csr_rdata = MARCHID_VAL;
         CSR_MHARTID:   csr_rdata = MHARTID_VAL;
`ifdef WBU_COUNTERS_EN
         CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = mcycle[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET:  csr_rdata = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
`endif
         default: csr_rdata = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_RUN;
         dnpc_q     <= '0;
         fencei_q   <= 1'b0;
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         mscratch_q <= '0;
      end else begin
         state_q    <= state_d;
         dnpc_q     <= dnpc_d;
         fencei_q   <= fencei_d;
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         mscratch_q <= mscratch_d;
      end
   end

endmodule

// File: tb/tb_wbu_trap_csr.sv
// Directed trap/mret/fence.i scenarios followed by random retirement traffic, all checked against
// an architectural CSR model; counter checks follow WBU_COUNTERS_EN.
`timescale 1ns/1ps
module tb_wbu_trap_csr;
   import wbu_csr_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        gpr_wen;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic        cs_flush;
   logic [31:0] cs_dnpc;
   logic        fencei;
   logic        in_ready;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [4:0]  in_gpr_waddr;
   logic [31:0] in_gpr_wdata;
   logic        in_csr_wen;
   logic [11:0] in_csr_waddr;
   logic [31:0] in_csr_wdata;
   logic        in_exc;
   logic [4:0]  in_exc_cause;
   logic [31:0] in_exc_tval;
   logic        in_ret;
   logic        in_fencei;

   always #5 clock = ~clock;

   wbu_trap_csr dut (
      .clock(clock), .reset(reset),
      .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .cs_flush(cs_flush), .cs_dnpc(cs_dnpc), .fencei(fencei),
      .in_ready(in_ready), .in_valid(in_valid), .in_pc(in_pc),
      .in_gpr_waddr(in_gpr_waddr), .in_gpr_wdata(in_gpr_wdata),
      .in_csr_wen(in_csr_wen), .in_csr_waddr(in_csr_waddr), .in_csr_wdata(in_csr_wdata),
      .in_exc(in_exc), .in_exc_cause(in_exc_cause), .in_exc_tval(in_exc_tval),
      .in_ret(in_ret), .in_fencei(in_fencei)
   );

   int n_pass = 0;
   int n_total = 0;
   int flush_pulses = 0;

   // Architectural model: plain variables per CSR plus "a flush is showing this cycle".
   bit          m_live = 0;
   bit          m_pend, m_pend_fi;
   logic [31:0] m_pend_dnpc;
   bit          m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
`ifdef WBU_COUNTERS_EN
   logic [63:0] m_cyc, m_ins;
`endif

   logic [11:0] addr_tab [18] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                  12'hF11, 12'hF12, 12'hF14, 12'hB00, 12'hB80, 12'hB02,
                                  12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h340: return m_mscratch;
         12'hF11: return 32'h7973_7978;
         12'hF12: return 32'h015f_deeb;
         12'hF14: return 32'h0;
`ifdef WBU_COUNTERS_EN
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic ref_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
         12'h305: m_mtvec = d & ~32'h3;
         12'h341: m_mepc = d & ~32'h3;
         12'h342: m_mcause = d;
         12'h343: m_mtval = d;
         12'h340: m_mscratch = d;
`ifdef WBU_COUNTERS_EN
         12'hB00: m_cyc = {m_cyc[63:32], d};
         12'hB80: m_cyc = {d, m_cyc[31:0]};
         12'hB02: m_ins = {m_ins[63:32], d};
         12'hB82: m_ins = {d, m_ins[31:0]};
`endif
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_pend = 0; m_pend_fi = 0; m_pend_dnpc = 0;
      m_mie = 0; m_mpie = 0; m_mtvec = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
`ifdef WBU_COUNTERS_EN
      m_cyc = 0; m_ins = 0;
`endif
      m_live = 1;
   endtask

   task automatic clear();
      in_valid = 0; in_pc = 0; in_gpr_waddr = 0; in_gpr_wdata = 0;
      in_csr_wen = 0; in_csr_waddr = 0; in_csr_wdata = 0;
      in_exc = 0; in_exc_cause = 0; in_exc_tval = 0; in_ret = 0; in_fencei = 0;
   endtask

   task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_raddr = a;
      #1;
      chk(tag, csr_rdata, exp);
   endtask

   // One clock: check combinational outputs, advance model on the edge, check registered outputs.
   task automatic tick();
      bit acc, exc, ret, cw, fl, wen_exp;
      logic [31:0] dn;
      #1;
      acc = in_valid && !m_pend;
      if (m_live && !reset) begin
         chk("in_ready", in_ready, !m_pend);
         wen_exp = acc && !in_exc && (in_gpr_waddr != 0);
         chk("gpr_wen", gpr_wen, wen_exp);
         if (wen_exp) begin
            chk("gpr_waddr", gpr_waddr, in_gpr_waddr);
            chk("gpr_wdata", gpr_wdata, in_gpr_wdata);
         end
         chk("csr_rdata", csr_rdata, ref_read(csr_raddr));
      end
      @(posedge clock);
      if (reset) begin
         model_reset();
      end else begin
         exc = acc && in_exc;
         ret = acc && in_ret && !in_exc;
         cw  = acc && in_csr_wen && !in_exc && !in_ret;
         fl  = acc && (in_exc || in_ret || in_csr_wen || in_fencei);
         dn  = exc ? m_mtvec : (ret ? m_mepc : in_pc + 32'd4);
`ifdef WBU_COUNTERS_EN
         m_cyc = m_cyc + 1;
         if (acc) m_ins = m_ins + 1;
         // a written counter takes the written half and skips this cycle's increment
         if (cw && (in_csr_waddr == 12'hB00 || in_csr_waddr == 12'hB80)) m_cyc = m_cyc - 1;
         if (cw && (in_csr_waddr == 12'hB02 || in_csr_waddr == 12'hB82)) m_ins = m_ins - 1;
`endif
         if (exc) begin
            m_mepc = in_pc; m_mcause = 32'(in_exc_cause); m_mtval = in_exc_tval;
            m_mpie = m_mie; m_mie = 0;
         end else if (ret) begin
            m_mie = m_mpie; m_mpie = 1;
         end else if (cw) begin
            ref_write(in_csr_waddr, in_csr_wdata);
         end
         if (fl) begin
            m_pend = 1; m_pend_dnpc = dn; m_pend_fi = in_fencei && !in_exc;
         end else begin
            m_pend = 0; m_pend_fi = 0;
         end
      end
      #1;
      if (m_live) begin
         chk("cs_flush", cs_flush, m_pend);
         chk("fencei", fencei, m_pend && m_pend_fi);
         if (m_pend) chk("cs_dnpc", cs_dnpc, m_pend_dnpc);
      end
      if (cs_flush) flush_pulses++;
   endtask

   initial begin
      clear();
      csr_raddr = 12'h300;
      reset = 1;
      tick();
      tick();
      reset = 0;

      peek("rst_mstatus", 12'h300, 32'h0000_1800);
      peek("rst_mtvec", 12'h305, 32'h0000_0000);
      peek("rst_mvendorid", 12'hF11, 32'h7973_7978);
      chk("rst_cs_flush", cs_flush, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      tick();

      // mtvec write, then ecall
      in_valid = 1; in_pc = 32'h100; in_csr_wen = 1; in_csr_waddr = 12'h305;
      in_csr_wdata = 32'h8000_0103;
      tick();
      clear();
      tick();
      in_valid = 1; in_pc = 32'h8000_0040; in_exc = 1; in_exc_cause = CAUSE_ECALL_M;
      in_exc_tval = 0; in_gpr_waddr = 5'd5; in_gpr_wdata = 32'hDEAD_BEEF;
      #1;
      chk("ecall_gpr_wen", gpr_wen, 1'b0);
      tick();
      chk("ecall_flush", cs_flush, 1'b1);
      chk("ecall_dnpc", cs_dnpc, 32'h8000_0100);
      chk("ecall_in_ready", in_ready, 1'b0);
      clear();
      peek("ecall_mepc", 12'h341, 32'h8000_0040);
      peek("ecall_mcause", 12'h342, 32'd11);
      peek("ecall_mstatus", 12'h300, 32'h0000_1800);
      tick();

      // MIE=1, ebreak, mret
      in_valid = 1; in_pc = 32'h1F0; in_csr_wen = 1; in_csr_waddr = 12'h300; in_csr_wdata = 32'h8;
      tick();
      clear();
      tick();
      in_valid = 1; in_pc = 32'h200; in_exc = 1; in_ret = 1; in_exc_cause = CAUSE_BREAKPOINT;
      tick();
      clear();
      peek("exc_mstatus", 12'h300, 32'h0000_1880);
      tick();
      in_valid = 1; in_pc = 32'h204; in_ret = 1;
      tick();
      chk("mret_dnpc", cs_dnpc, 32'h0000_0200);
      clear();
      peek("mret_mstatus", 12'h300, 32'h0000_1888);
      tick();

      // back-to-back: csrw then a plain instruction held through the flush cycle
      flush_pulses = 0;
      in_valid = 1; in_pc = 32'h300; in_csr_wen = 1; in_csr_waddr = 12'h340;
      in_csr_wdata = 32'h1234;
      tick();
      in_csr_wen = 0; in_pc = 32'h304; in_gpr_waddr = 5'd3; in_gpr_wdata = 32'hABCD;
      #1;
      chk("b2b_held_ready", in_ready, 1'b0);
      chk("b2b_held_wen", gpr_wen, 1'b0);
      tick();
      #1;
      chk("b2b_accept_wen", gpr_wen, 1'b1);
      tick();
      clear();
      tick();
      tick();
      chk("b2b_flush_pulses", flush_pulses, 1);

      // fence.i at the top of the address space
      in_valid = 1; in_pc = 32'hFFFF_FFFC; in_fencei = 1;
      tick();
      chk("fencei_flush", cs_flush, 1'b1);
      chk("fencei_pulse", fencei, 1'b1);
      chk("fencei_dnpc", cs_dnpc, 32'h0000_0000);
      clear();
      tick();

`ifdef WBU_COUNTERS_EN
      in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'hB80; in_csr_wdata = 0;
      tick();
      clear();
      tick();
      in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'hB00; in_csr_wdata = 32'hFFFF_FFFF;
      tick();
      clear();
      tick();
      peek("mcycleh_carry", 12'hB80, 32'h1);
      peek("cycleh_alias", 12'hC80, 32'h1);
      peek("mcycle_wrapped", 12'hB00, 32'h0);
      tick();
`else
      peek("no_counter_b00", 12'hB00, 32'h0);
      peek("no_counter_c82", 12'hC82, 32'h0);
      tick();
`endif

      // reset while a flush is showing drops it
      in_valid = 1; in_csr_wen = 1; in_csr_waddr = 12'h340; in_csr_wdata = 32'h55;
      tick();
      clear();
      reset = 1;
      tick();
      reset = 0;
      chk("rst_drop_flush", cs_flush, 1'b0);
      tick();

      // random retirement traffic
      for (int i = 0; i < 400; i++) begin
         in_valid     = ($urandom % 4) != 0;
         in_pc        = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3);
         in_gpr_waddr = 5'($urandom % 32);
         in_gpr_wdata = $urandom;
         in_exc       = ($urandom % 10) == 0;
         in_exc_cause = 5'($urandom % 32);
         in_exc_tval  = $urandom;
         in_ret       = ($urandom % 10) == 0;
         in_csr_wen   = ($urandom % 4) == 0;
         in_csr_waddr = addr_tab[$urandom % 18];
         in_csr_wdata = $urandom;
         in_fencei    = ($urandom % 12) == 0;
         csr_raddr    = addr_tab[$urandom % 18];
         tick();
      end
      clear();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
